// File: rtl/jk_pkg.sv
// Shared types and constants for the JK bank driver.
// States of the drive/check loop and excitation fill modes.
package jk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] MODE_MINIMAL = 2'd0;
  localparam logic [1:0] MODE_FORCE   = 2'd1;
  localparam logic [1:0] MODE_TOGGLE  = 2'd2;

  localparam int RETRY_W = 4;

endpackage

// File: rtl/jk_excite.sv
// Per-word JK excitation: J/K that move each bit from cur to tgt.
// Purely combinational; reusable by any JK-based generator.
module jk_excite
  import jk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [1:0]   mode,
  output logic [W-1:0] j,
  output logic [W-1:0] k
);

  logic [W-1:0] w_diff;

  assign w_diff = cur ^ tgt;

  always_comb begin
    j = '0;
    k = '0;
    case (mode)
      MODE_FORCE: begin
        j = tgt;
        k = ~tgt;
      end
      MODE_TOGGLE: begin
        j = w_diff;
        k = w_diff;
      end
      default: begin
        j = w_diff & tgt;
        k = w_diff & cur;
      end
    endcase
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives J/K of an external JK bank until its Q matches a target,
// retrying a bounded number of times before flagging an error.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int W         = 8,
  parameter int MODE      = 0,
  parameter int MAX_RETRY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] tgt_data,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [1:0] MODE_SEL = MODE[1:0];
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  state_t r_state;
  state_t w_next;

  logic [W-1:0]       r_tgt;
  logic [W-1:0]       r_j;
  logic [W-1:0]       r_k;
  logic [RETRY_W-1:0] r_retry;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_match;
  logic               w_load;
  logic               w_inc;
  logic [W-1:0]       w_sel_tgt;
  logic [W-1:0]       w_ex_j;
  logic [W-1:0]       w_ex_k;

  assign tgt_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = tgt_valid & tgt_ready;
  assign w_match   = (q_fb == r_tgt);

  // On accept the fresh request word is not yet captured.
  assign w_sel_tgt = (r_state == IDLE) ? tgt_data : r_tgt;

  jk_excite #(
    .W(W)
  ) u_excite (
    .cur  (q_fb),
    .tgt  (w_sel_tgt),
    .mode (MODE_SEL),
    .j    (w_ex_j),
    .k    (w_ex_k)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_inc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = DRIVE;
          w_load = 1'b1;
        end
      end
      DRIVE: w_next = CHECK;
      CHECK: begin
        if (w_match) begin
          w_next = DONE;
        end else if (r_retry < MAX_R) begin
          w_next = DRIVE;
          w_load = 1'b1;
          w_inc  = 1'b1;
        end else begin
          w_next = ERR;
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tgt   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_retry <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == DONE);
      r_err   <= (w_next == ERR);
      // J/K are only non-zero for the single DRIVE cycle.
      if (w_load) begin
        r_j <= w_ex_j;
        r_k <= w_ex_k;
      end else begin
        r_j <= '0;
        r_k <= '0;
      end
      if (w_accept) begin
        r_tgt   <= tgt_data;
        r_retry <= '0;
      end else if (w_inc) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

  assign j    = r_j;
  assign k    = r_k;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: four drivers (MINIMAL, FORCE, TOGGLE,
// MINIMAL with no retries), each with its own modelled JK bank.
module tb_jk_bank_driver;

  localparam int W  = 8;
  localparam int NU = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NU-1:0]        tv, rdy, busy, dn, er, ld;
  logic [NU-1:0][W-1:0] td, qfb, jo, ko, bank, stk, ldv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lat; bit is_err; bit both; bit rdy_after; bit tmo;
    int drives; logic [W-1:0] j1; logic [W-1:0] k1;
  } obs_t;

  typedef struct {
    int lat; bit is_err; int drives;
    logic [W-1:0] j1; logic [W-1:0] k1; logic [W-1:0] bank;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_u
    localparam int M = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int R = (g == 3) ? 0 : 2;
    jk_bank_driver #(.W(W), .MODE(M), .MAX_RETRY(R)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .tgt_valid(tv[g]), .tgt_ready(rdy[g]), .tgt_data(td[g]),
      .q_fb(qfb[g]), .j(jo[g]), .k(ko[g]),
      .busy(busy[g]), .done(dn[g]), .err(er[g])
    );
  end

  // JK bank model: Q+ = J.~Q | ~K.Q, with stuck-at-0 output bits.
  always @(posedge clk)
    for (int i = 0; i < NU; i++)
      if (ld[i]) bank[i] <= ldv[i];
      else bank[i] <= (jo[i] & ~bank[i]) | (~ko[i] & bank[i]);

  always_comb
    for (int i = 0; i < NU; i++) qfb[i] = bank[i] & ~stk[i];

  function automatic int mode_of(input int u);
    return (u == 1) ? 1 : (u == 2) ? 2 : 0;
  endfunction

  function automatic void exp_jk(input int m, input logic [W-1:0] c,
                                 input logic [W-1:0] t,
                                 output logic [W-1:0] ej,
                                 output logic [W-1:0] ek);
    for (int b = 0; b < W; b++) begin
      ej[b] = 1'b0;
      ek[b] = 1'b0;
      if (m == 1) begin
        ej[b] = t[b];
        ek[b] = !t[b];
      end else if (c[b] != t[b]) begin
        if (m == 2) begin
          ej[b] = 1'b1;
          ek[b] = 1'b1;
        end else if (t[b]) ej[b] = 1'b1;
        else ek[b] = 1'b1;
      end
    end
  endfunction

  task automatic preload(input int u, input logic [W-1:0] v);
    @(negedge clk);
    ld[u] = 1'b1;
    ldv[u] = v;
    @(negedge clk);
    ld[u] = 1'b0;
  endtask

  task automatic send(input int u, input logic [W-1:0] tgt, output obs_t o);
    int n;
    o.lat = 0; o.is_err = 0; o.both = 0; o.rdy_after = 0; o.tmo = 0;
    o.drives = 0; o.j1 = '0; o.k1 = '0;
    @(negedge clk);
    td[u] = tgt;
    tv[u] = 1'b1;
    n = 0;
    while (!rdy[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[u]) begin
      tv[u] = 1'b0;
      o.tmo = 1;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      tv[u] = 1'b0;
      td[u] = W'($urandom);
      if (jo[u] != '0 || ko[u] != '0) begin
        if (o.drives == 0) begin
          o.j1 = jo[u];
          o.k1 = ko[u];
        end
        o.drives++;
      end
      if (dn[u] && er[u]) o.both = 1;
      if (dn[u] || er[u]) begin
        o.lat = c;
        o.is_err = er[u];
        @(negedge clk);
        o.rdy_after = rdy[u];
        return;
      end
    end
    o.tmo = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (jo !== '0 || ko !== '0) begin
      errors++;
      $display("FAIL reset_jk: j=%h k=%h want 0", jo, ko);
    end
    checks++;
    if (dn !== '0 || er !== '0 || busy !== '0) begin
      errors++;
      $display("FAIL reset_flags: done=%b err=%b busy=%b want 0", dn, er, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== '1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1111", rdy);
    end
  endtask

  task automatic test_modes();
    int u_t[4] = '{0, 2, 1, 0};
    logic [W-1:0] b_t[4] = '{8'h00, 8'hF0, 8'h3C, 8'h5A};
    logic [W-1:0] t_t[4] = '{8'hA5, 8'h0F, 8'h3C, 8'h5A};
    logic [W-1:0] j_t[4] = '{8'hA5, 8'hFF, 8'h3C, 8'h00};
    logic [W-1:0] k_t[4] = '{8'h00, 8'hFF, 8'hC3, 8'h00};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      preload(u_t[i], b_t[i]);
      sb.push_back('{lat: 3, is_err: 0, drives: (j_t[i] | k_t[i]) != 0,
                     j1: j_t[i], k1: k_t[i], bank: t_t[i]});
      send(u_t[i], t_t[i], o);
      e = sb.pop_front();
      checks++;
      if (o.tmo || o.lat !== e.lat || o.is_err !== e.is_err) begin
        errors++;
        $display("FAIL mode%0d_lat: lat=%0d err=%b tmo=%b want lat=%0d err=0",
                 i, o.lat, o.is_err, o.tmo, e.lat);
      end
      checks++;
      if (o.j1 !== e.j1 || o.k1 !== e.k1 || o.drives !== e.drives) begin
        errors++;
        $display("FAIL mode%0d_jk: j=%h k=%h drv=%0d want j=%h k=%h drv=%0d",
                 i, o.j1, o.k1, o.drives, e.j1, e.k1, e.drives);
      end
      checks++;
      if (qfb[u_t[i]] !== e.bank || !o.rdy_after) begin
        errors++;
        $display("FAIL mode%0d_bank: bank=%h rdy=%b want bank=%h rdy=1",
                 i, qfb[u_t[i]], o.rdy_after, e.bank);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [W-1:0] c, t, ej, ek;
    for (int i = 0; i < 6; i++) begin
      int u = i % 3;
      c = W'($urandom);
      t = W'($urandom);
      exp_jk(mode_of(u), c, t, ej, ek);
      preload(u, c);
      sb.push_back('{lat: 3, is_err: 0, drives: (ej | ek) != 0,
                     j1: ej, k1: ek, bank: t});
      send(u, t, o);
      e = sb.pop_front();
      checks++;
      if (o.tmo || o.lat !== e.lat || o.j1 !== e.j1 || o.k1 !== e.k1 ||
          qfb[u] !== e.bank || o.both) begin
        errors++;
        $display("FAIL rand%0d u%0d: lat=%0d j=%h k=%h bank=%h want lat=%0d j=%h k=%h bank=%h",
                 i, u, o.lat, o.j1, o.k1, qfb[u], e.lat, e.j1, e.k1, e.bank);
      end
    end
  endtask

  task automatic test_stuck();
    obs_t o;
    exp_t e;
    int u_t[2] = '{0, 3};
    int lat_t[2] = '{7, 3};
    int drv_t[2] = '{3, 1};
    for (int i = 0; i < 2; i++) begin
      int u = u_t[i];
      stk[u] = 8'h01;
      preload(u, 8'h00);
      sb.push_back('{lat: lat_t[i], is_err: 1, drives: drv_t[i],
                     j1: 8'h01, k1: 8'h00, bank: 8'h00});
      send(u, 8'h01, o);
      e = sb.pop_front();
      checks++;
      if (o.tmo || o.lat !== e.lat || o.is_err !== 1'b1 || o.both) begin
        errors++;
        $display("FAIL stuck%0d_err: lat=%0d err=%b both=%b want lat=%0d err=1",
                 i, o.lat, o.is_err, o.both, e.lat);
      end
      checks++;
      if (o.drives !== e.drives || o.j1 !== e.j1 || o.k1 !== e.k1) begin
        errors++;
        $display("FAIL stuck%0d_drv: drv=%0d j=%h k=%h want drv=%0d j=%h k=%h",
                 i, o.drives, o.j1, o.k1, e.drives, e.j1, e.k1);
      end
      checks++;
      if (o.rdy_after !== 1'b1) begin
        errors++;
        $display("FAIL stuck%0d_ready: got %b want 1", i, o.rdy_after);
      end
      stk[u] = 8'h00;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    int seen;
    preload(0, 8'h00);
    @(negedge clk);
    td[0] = 8'h55;
    tv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tv[0] = 1'b0;
    checks++;
    if (jo[0] !== 8'h55 || ko[0] !== 8'h00) begin
      errors++;
      $display("FAIL rmid_drive: j=%h k=%h want j=55 k=00", jo[0], ko[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (jo[0] !== '0 || ko[0] !== '0 || busy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_abort: j=%h k=%h busy=%b rdy=%b want 0 0 0 1",
               jo[0], ko[0], busy[0], rdy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dn[0] || er[0]) seen++;
    end
    checks++;
    if (seen != 0 || qfb[0] !== 8'h00) begin
      errors++;
      $display("FAIL rmid_quiet: pulses=%0d bank=%h want 0 and 00", seen, qfb[0]);
    end
    sb.push_back('{lat: 3, is_err: 0, drives: 1, j1: 8'hA5, k1: 8'h00, bank: 8'hA5});
    send(0, 8'hA5, o);
    e = sb.pop_front();
    checks++;
    if (o.tmo || o.lat !== e.lat || o.is_err || o.j1 !== e.j1 || qfb[0] !== e.bank) begin
      errors++;
      $display("FAIL rmid_next: lat=%0d err=%b j=%h bank=%h want lat=3 err=0 j=%h bank=%h",
               o.lat, o.is_err, o.j1, qfb[0], e.j1, e.bank);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n_done, n_err, t_done[2];
    logic [W-1:0] j_obs[2], k_obs[2];
    logic r4, r5;
    preload(0, 8'h00);
    sb.push_back('{lat: 3, is_err: 0, drives: 1, j1: 8'h3C, k1: 8'h00, bank: 8'h3C});
    sb.push_back('{lat: 7, is_err: 0, drives: 1, j1: 8'hC3, k1: 8'h3C, bank: 8'hC3});
    @(negedge clk);
    td[0] = 8'h3C;
    tv[0] = 1'b1;
    @(posedge clk);
    n_done = 0; n_err = 0; r4 = 0; r5 = 1;
    t_done = '{0, 0};
    j_obs = '{8'h00, 8'h00};
    k_obs = '{8'h00, 8'h00};
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c < 3) td[0] = W'($urandom);
      else if (c < 5) td[0] = 8'hC3;
      else begin
        td[0] = W'($urandom);
        tv[0] = 1'b0;
      end
      if (c == 1) begin j_obs[0] = jo[0]; k_obs[0] = ko[0]; end
      if (c == 5) begin j_obs[1] = jo[0]; k_obs[1] = ko[0]; end
      if (c == 4) r4 = rdy[0];
      if (c == 5) r5 = rdy[0];
      if (er[0]) n_err++;
      if (dn[0]) begin
        if (n_done < 2) t_done[n_done] = c;
        n_done++;
      end
    end
    checks++;
    if (n_done != 2 || n_err != 0) begin
      errors++;
      $display("FAIL b2b_count: done=%0d err=%0d want 2 and 0", n_done, n_err);
    end
    checks++;
    if (r4 !== 1'b1 || r5 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready: c4=%b c5=%b want 1 0", r4, r5);
    end
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      checks++;
      if (t_done[i] !== e.lat || j_obs[i] !== e.j1 || k_obs[i] !== e.k1) begin
        errors++;
        $display("FAIL b2b_req%0d: t=%0d j=%h k=%h want t=%0d j=%h k=%h",
                 i, t_done[i], j_obs[i], k_obs[i], e.lat, e.j1, e.k1);
      end
      if (i == 1) begin
        checks++;
        if (qfb[0] !== e.bank) begin
          errors++;
          $display("FAIL b2b_bank: got %h want %h", qfb[0], e.bank);
        end
      end
    end
  endtask

  initial begin
    tv = '0; td = '0; stk = '0; ld = '1; ldv = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ld = '0;
    test_reset();
    test_modes();
    test_random();
    test_stuck();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
